diag_scheduler: RTL

DIAG_SCHEDULER -- requirements
Module: diag_scheduler

---
 rtl/diag_scheduler_pkg.sv | 20 ++
 rtl/diag_scheduler_if.sv | 28 ++
 rtl/diag_scheduler_diag_mask_gen.sv | 21 ++
 rtl/diag_scheduler.sv | 97 +++++++++
 4 files changed

// File: rtl/diag_scheduler_pkg.sv
// Shared types and sizing for the anti-diagonal alignment scheduler.
package design_variables;

  localparam int unsigned NUM_PU_MAIN_DIAGONAL = 16;
  localparam int unsigned NUM_DIAGONALS        = 2 * NUM_PU_MAIN_DIAGONAL - 1;
  localparam int unsigned NUM_DIAGONALS_W      = 5;

  localparam int unsigned PU_STEPS_DEFAULT     = 3;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    TRACE,
    FIN
  } sched_state_t;

endpackage

// File: rtl/diag_scheduler_if.sv
// Handshake and control bundle between the alignment controller and the PU array.
interface diag_scheduler_if;
  import design_variables::*;

  logic                            start;
  logic                            load_done;
  logic                            stall;
  logic                            tb_done;
  logic                            buf_load_en;
  logic [NUM_DIAGONALS_W-1:0]      diag_idx;
  logic [1:0]                      pe_phase;
  logic [NUM_PU_MAIN_DIAGONAL-1:0] pu_row_en;
  logic                            max_en;
  logic                            tb_start;
  logic                            busy;
  logic                            done;

  modport master (
    output start, load_done, stall, tb_done,
    input  buf_load_en, diag_idx, pe_phase, pu_row_en, max_en, tb_start, busy, done
  );

  modport slave (
    input  start, load_done, stall, tb_done,
    output buf_load_en, diag_idx, pe_phase, pu_row_en, max_en, tb_start, busy, done
  );

endinterface

// File: rtl/diag_scheduler_diag_mask_gen.sv
// Decodes the current anti-diagonal into the set of PU rows that hold a valid cell.
module diag_mask_gen
  import design_variables::*;
(
  input  logic [NUM_DIAGONALS_W-1:0]      diag_idx,
  input  logic                            en,
  output logic [NUM_PU_MAIN_DIAGONAL-1:0] pu_row_en
);

  always_comb begin
    pu_row_en = '0;
    if (en) begin
      for (int unsigned r = 0; r < NUM_PU_MAIN_DIAGONAL; r++) begin
        // Row r is live when its column (diag - r) lies inside the array.
        if ((32'(diag_idx) >= r) && ((32'(diag_idx) - r) <= (NUM_PU_MAIN_DIAGONAL - 1)))
          pu_row_en[r] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/diag_scheduler.sv
// Alignment sequencer: load, sweep anti-diagonals, drain, launch traceback.
// Optional macro DIAG_SCHED_STALL_EN lets stall freeze the COMPUTE sweep.
module diag_scheduler
  import design_variables::*;
#(
  parameter int unsigned PU_STEPS     = PU_STEPS_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  diag_scheduler_if.slave sif
);

  localparam logic [NUM_DIAGONALS_W-1:0] LAST_DIAG  = NUM_DIAGONALS_W'(NUM_DIAGONALS - 1);
  localparam logic [1:0]                 LAST_PHASE = 2'(PU_STEPS - 1);
  localparam logic [7:0]                 LAST_DRAIN = 8'(DRAIN_CYCLES - 1);

  sched_state_t               state, state_nx;
  logic [NUM_DIAGONALS_W-1:0] diag_q;
  logic [1:0]                 phase_q;
  logic [7:0]                 drain_cnt;
  logic                       trace_seen;
  logic                       stalled;
  logic                       last_step;
  logic                       mask_en;

`ifdef DIAG_SCHED_STALL_EN
  assign stalled = (state == COMPUTE) && sif.stall;
`else
  logic unused_stall;
  assign unused_stall = sif.stall;
  assign stalled      = 1'b0;
`endif

  assign last_step = (diag_q == LAST_DIAG) && (phase_q == LAST_PHASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sif.start)                state_nx = LOAD;
      LOAD:    if (sif.load_done)            state_nx = COMPUTE;
      COMPUTE: if (!stalled && last_step)    state_nx = DRAIN;
      DRAIN:   if (drain_cnt == LAST_DRAIN)  state_nx = TRACE;
      TRACE:   if (sif.tb_done)              state_nx = FIN;
      FIN:                                   state_nx = IDLE;
      default:                               state_nx = IDLE;
    endcase
  end

  // The final step holds 30/PU_STEPS-1 rather than stepping past the last diagonal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diag_q     <= '0;
      phase_q    <= '0;
      drain_cnt  <= '0;
      trace_seen <= 1'b0;
    end else begin
      if (state == LOAD && sif.load_done) begin
        diag_q  <= '0;
        phase_q <= '0;
      end else if (state == COMPUTE && !stalled && !last_step) begin
        if (phase_q == LAST_PHASE) begin
          phase_q <= '0;
          diag_q  <= diag_q + NUM_DIAGONALS_W'(1);
        end else begin
          phase_q <= phase_q + 2'd1;
        end
      end
      drain_cnt  <= (state == DRAIN) ? drain_cnt + 8'd1 : '0;
      trace_seen <= (state == TRACE);
    end
  end

  assign mask_en = (state == COMPUTE) && !stalled;

  diag_mask_gen u_mask (
    .diag_idx  (diag_q),
    .en        (mask_en),
    .pu_row_en (sif.pu_row_en)
  );

  always_comb begin
    sif.buf_load_en = (state == LOAD);
    sif.diag_idx    = diag_q;
    sif.pe_phase    = phase_q;
    sif.max_en      = mask_en && (phase_q == LAST_PHASE);
    sif.tb_start    = (state == TRACE) && !trace_seen;
    sif.busy        = (state != IDLE);
    sif.done        = (state == FIN);
  end

endmodule
